// File: rtl/dpram_bist.sv
// dpram_bist: march-style self-test for one synchronous RAM port.
// Writes P(a) = 8'hA5 ^ a to every word, reads it back, then repeats
// the pass with the inverted pattern ~P(a). Each read is compared one
// cycle after it is issued.
// Optional feature: define DPRAM_BIST_ERRLOG_EN to add a saturating
// mismatch counter (err_cnt). A run then never aborts early. Without
// the macro, the first mismatch ends the run.
module dpram_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase
`ifdef DPRAM_BIST_ERRLOG_EN
  ,
  output logic [3:0]        err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Test pattern for address a; phase 1 is the bitwise inverse of phase 0.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic              ph);
    logic [DATA_W-1:0] base;
    base = DATA_W'(8'hA5) ^ DATA_W'(a);
    return ph ? ~base : base;
  endfunction

  state_t              state, nxt_state;
  logic                drain, nxt_drain;          // post-read cycle that lets the last read be compared
  logic                cmp_valid, nxt_cmp_valid;  // a read was issued last cycle
  logic [ADDR_W-1:0]   cmp_addr, nxt_cmp_addr;
  logic                cmp_phase, nxt_cmp_phase;
  logic                fail_seen, nxt_fail_seen;  // first mismatch of this run already captured
  logic                mismatch;

  logic                nxt_ram_en;
  logic [ADDR_W-1:0]   nxt_ram_addr;
  logic [DATA_W-1:0]   nxt_ram_wdata;
  logic                nxt_busy, nxt_done, nxt_pass;
  logic [ADDR_W-1:0]   nxt_fail_addr;
  logic                nxt_fail_phase;
`ifdef DPRAM_BIST_ERRLOG_EN
  logic [3:0]          nxt_err_cnt;
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    nxt_state      = state;
    nxt_drain      = 1'b0;
    nxt_cmp_valid  = 1'b0;
    nxt_cmp_addr   = ram_addr;
    nxt_cmp_phase  = (state == RD1);
    nxt_fail_seen  = fail_seen;
    nxt_ram_en     = 1'b0;
    nxt_ram_addr   = ram_addr;
    nxt_ram_wdata  = '0;
    nxt_busy       = busy;
    nxt_done       = done;
    nxt_pass       = pass;
    nxt_fail_addr  = fail_addr;
    nxt_fail_phase = fail_phase;
`ifdef DPRAM_BIST_ERRLOG_EN
    nxt_err_cnt    = err_cnt;
`endif
    mismatch       = 1'b0;

    unique case (state)
      IDLE: begin
        nxt_ram_addr = '0;
        if (start) begin
          nxt_state      = WR0;
          nxt_busy       = 1'b1;
          nxt_done       = 1'b0;
          nxt_pass       = 1'b0;
          nxt_fail_addr  = '0;
          nxt_fail_phase = 1'b0;
          nxt_fail_seen  = 1'b0;
`ifdef DPRAM_BIST_ERRLOG_EN
          nxt_err_cnt    = 4'd0;
`endif
          nxt_ram_en     = 1'b1;
          nxt_ram_wdata  = pattern({ADDR_W{1'b0}}, 1'b0);
        end
      end

      WR0, WR1: begin
        if (ram_addr == LAST_ADDR) begin
          nxt_state    = (state == WR0) ? RD0 : RD1;
          nxt_ram_addr = '0;
        end else begin
          nxt_ram_en    = 1'b1;
          nxt_ram_addr  = ram_addr + ADDR_W'(1);
          nxt_ram_wdata = pattern(ram_addr + ADDR_W'(1), state == WR1);
        end
      end

      RD0, RD1: begin
        mismatch = cmp_valid && (ram_rdata != pattern(cmp_addr, cmp_phase));
        if (!drain) begin
          nxt_cmp_valid = 1'b1;
          if (ram_addr == LAST_ADDR) nxt_drain    = 1'b1;
          else                       nxt_ram_addr = ram_addr + ADDR_W'(1);
        end else if (state == RD0) begin
          nxt_state     = WR1;
          nxt_ram_en    = 1'b1;
          nxt_ram_addr  = '0;
          nxt_ram_wdata = pattern({ADDR_W{1'b0}}, 1'b1);
        end else begin
          nxt_state    = FIN;
          nxt_ram_addr = '0;
          nxt_busy     = 1'b0;
          nxt_done     = 1'b1;
          nxt_pass     = !(fail_seen || mismatch);
        end

        if (mismatch && !fail_seen) begin
          nxt_fail_addr  = cmp_addr;
          nxt_fail_phase = cmp_phase;
          nxt_fail_seen  = 1'b1;
        end
`ifdef DPRAM_BIST_ERRLOG_EN
        if (mismatch && err_cnt != 4'hF) nxt_err_cnt = err_cnt + 4'd1;
`else
        // Abort: drop any pending access and report immediately.
        if (mismatch) begin
          nxt_state     = FIN;
          nxt_ram_en    = 1'b0;
          nxt_ram_addr  = '0;
          nxt_ram_wdata = '0;
          nxt_drain     = 1'b0;
          nxt_cmp_valid = 1'b0;
          nxt_busy      = 1'b0;
          nxt_done      = 1'b1;
          nxt_pass      = 1'b0;
        end
`endif
      end

      FIN: begin
        nxt_state    = IDLE;
        nxt_ram_addr = '0;
      end

      default: nxt_state = IDLE;
    endcase
  end

  // State, compare pipeline and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drain      <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_addr   <= '0;
      cmp_phase  <= 1'b0;
      fail_seen  <= 1'b0;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_phase <= 1'b0;
`ifdef DPRAM_BIST_ERRLOG_EN
      err_cnt    <= 4'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= nxt_state;
      drain      <= nxt_drain;
      cmp_valid  <= nxt_cmp_valid;
      cmp_addr   <= nxt_cmp_addr;
      cmp_phase  <= nxt_cmp_phase;
      fail_seen  <= nxt_fail_seen;
      ram_en     <= nxt_ram_en;
      ram_addr   <= nxt_ram_addr;
      ram_wdata  <= nxt_ram_wdata;
      busy       <= nxt_busy;
      done       <= nxt_done;
      pass       <= nxt_pass;
      fail_addr  <= nxt_fail_addr;
      fail_phase <= nxt_fail_phase;
`ifdef DPRAM_BIST_ERRLOG_EN
      err_cnt    <= nxt_err_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_dpram_bist.sv
// tb_dpram_bist: directed bench for dpram_bist (DEPTH=4 main instance,
// DEPTH=1 second instance). Synchronous RAM models with injectable read
// faults. Builds with or without DPRAM_BIST_ERRLOG_EN.
module tb_dpram_bist;

  logic       clk = 1'b0;
  logic       rst, start, start1;

  logic       ram_en, busy, done, pass, fail_phase;
  logic [1:0] ram_addr, fail_addr;
  logic [7:0] ram_wdata, ram_rdata;

  logic       ram1_en, busy1, done1, pass1, fail_phase1;
  logic [0:0] ram1_addr, fail_addr1;
  logic [7:0] ram1_wdata, ram1_rdata;
`ifdef DPRAM_BIST_ERRLOG_EN
  logic [3:0] err_cnt, err_cnt1;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int fault_mode = 0;

  always #5 clk = ~clk;

  dpram_bist #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_phase(fail_phase)
`ifdef DPRAM_BIST_ERRLOG_EN
    , .err_cnt(err_cnt)
`endif
  );

  dpram_bist #(.DATA_W(8), .ADDR_W(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .ram_en(ram1_en), .ram_addr(ram1_addr), .ram_wdata(ram1_wdata), .ram_rdata(ram1_rdata),
    .busy(busy1), .done(done1), .pass(pass1), .fail_addr(fail_addr1), .fail_phase(fail_phase1)
`ifdef DPRAM_BIST_ERRLOG_EN
    , .err_cnt(err_cnt1)
`endif
  );

  // Read-path fault injection for the DEPTH=4 RAM model.
  function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [1:0] a, input int m);
    logic [7:0] p0;
    logic [7:0] r;
    p0 = 8'hA5 ^ {6'b0, a};
    r  = d;
    case (m)
      1: if (a == 2'd2) r[0] = 1'b1;                                   // stuck-at-1 bit 0
      2: if ((a == 2'd1 || a == 2'd3) && d == p0) r[0] = ~r[0];        // phase 0, addr 1 and 3
      3: if (a == 2'd0 && d == p0) r[0] = ~r[0];                       // phase 0, first read
      4: if (a == 2'd3 && d == ~p0) r[0] = ~r[0];                      // phase 1, last read
      default: ;
    endcase
    return r;
  endfunction

  logic [7:0] mem0 [4];
  logic [7:0] mem1 [2];
  logic [9:0] wr_log [$];

  // Synchronous RAM models: write when enabled, otherwise registered read.
  always @(posedge clk) begin
    if (ram_en) mem0[ram_addr] <= ram_wdata;
    else        ram_rdata <= rd_fault(mem0[ram_addr], ram_addr, fault_mode);
    if (ram1_en) mem1[ram1_addr] <= ram1_wdata;
    else         ram1_rdata <= mem1[ram1_addr];
  end

  // Record every write issued by the main instance.
  always @(posedge clk) if (ram_en) wr_log.push_back({ram_addr, ram_wdata});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Pulse start on one instance and count busy cycles until done (bounded).
  task automatic run_one(input bit which, output int nbusy);
    @(negedge clk);
    if (which) start1 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start1 = 1'b0;
    nbusy  = 0;
    for (int i = 0; i < 200; i++) begin
      if (which ? done1 : done) break;
      if (which ? busy1 : busy) nbusy++;
      @(negedge clk);
    end
    check("run_completes", {31'b0, (which ? done1 : done)}, 32'd1);
  endtask

  typedef struct {
    int   fault;
    int   busy;
    logic pass;
    int   fa;
    logic fp;
    int   err;
  } vec_t;

  vec_t        vecs [5];
  logic [9:0]  exp_wr [8];

  initial begin
    int nb;
    int rises, gap, bad;
    logic prev;

    vecs[0] = '{0, 18, 1'b1, 0, 1'b0, 0};
`ifdef DPRAM_BIST_ERRLOG_EN
    vecs[1] = '{1, 18, 1'b0, 2, 1'b1, 1};
    vecs[2] = '{2, 18, 1'b0, 1, 1'b0, 2};
    vecs[3] = '{3, 18, 1'b0, 0, 1'b0, 1};
    vecs[4] = '{4, 18, 1'b0, 3, 1'b1, 1};
`else
    vecs[1] = '{1, 17, 1'b0, 2, 1'b1, 0};
    vecs[2] = '{2,  7, 1'b0, 1, 1'b0, 0};
    vecs[3] = '{3,  6, 1'b0, 0, 1'b0, 0};
    vecs[4] = '{4, 18, 1'b0, 3, 1'b1, 0};
`endif
    exp_wr = '{10'h0A5, 10'h1A4, 10'h2A7, 10'h3A6, 10'h05A, 10'h15B, 10'h258, 10'h359};

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ram_en, ram_addr, ram_wdata, busy, done, pass, fail_addr, fail_phase}, 32'd0);
    check("reset_outputs_d1", {ram1_en, ram1_addr, ram1_wdata, busy1, done1, pass1, fail_addr1, fail_phase1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven runs: fault-free and several fault placements.
    for (int v = 0; v < 5; v++) begin
      fault_mode = vecs[v].fault;
      wr_log.delete();
      run_one(1'b0, nb);
      check($sformatf("v%0d_busy_cycles", v), nb, vecs[v].busy);
      check($sformatf("v%0d_done", v), {31'b0, done}, 32'd1);
      check($sformatf("v%0d_pass", v), {31'b0, pass}, {31'b0, vecs[v].pass});
      check($sformatf("v%0d_fail_addr", v), {30'b0, fail_addr}, vecs[v].fa);
      check($sformatf("v%0d_fail_phase", v), {31'b0, fail_phase}, {31'b0, vecs[v].fp});
`ifdef DPRAM_BIST_ERRLOG_EN
      check($sformatf("v%0d_err_cnt", v), {28'b0, err_cnt}, vecs[v].err);
`endif
      if (vecs[v].fault == 0) begin
        check("wr_count", wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++)
          check($sformatf("wr_seq_%0d", i), {22'b0, wr_log[i]}, {22'b0, exp_wr[i]});
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_idle_hold", v), {done, pass, busy, ram_en, ram_addr, ram_wdata},
            {1'b1, vecs[v].pass, 1'b0, 1'b0, 2'b00, 8'h00});
    end
    fault_mode = 0;

    // DEPTH=1 instance: 6 busy cycles, pass.
    run_one(1'b1, nb);
    check("d1_busy_cycles", nb, 6);
    check("d1_pass", {31'b0, pass1}, 32'd1);

    // Reset in busy cycle 7 abandons the run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {ram_en, ram_addr, ram_wdata, busy, done, pass, fail_addr, fail_phase}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", {busy, done}, 32'd0);
    run_one(1'b0, nb);
    check("post_reset_busy_cycles", nb, 18);
    check("post_reset_pass", {31'b0, pass}, 32'd1);

    // Start held for 30 cycles: one run per IDLE visit, FIN ignores start.
    repeat (2) @(negedge clk);
    wr_log.delete();
    rises = 0; gap = 0; prev = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      if (!busy && rises == 1) gap++;
      prev = busy;
    end
    start = 1'b0;
    check("held_start_runs", rises, 2);
    check("held_start_gap", gap, 2);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("held_start_done", {31'b0, done}, 32'd1);
    check("held_start_pass", {31'b0, pass}, 32'd1);
    check("held_start_wr_count", wr_log.size(), 16);
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++)
      if (wr_log[i][9:8] != 2'(i % 4)) bad++;
    check("held_start_addr_seq", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dpram_bist.md
DPRAM_BIST -- requirements
Module: dpram_bist

Interface
REQ-001 Parameter: DATA_W, default 8, data width of the tested RAM port.
REQ-002 Parameter: ADDR_W, default 2, address width of the tested RAM port.
REQ-003 Parameter: DEPTH, default 4, number of words tested (addresses 0..DEPTH-1); SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  begin a test run; sampled only in IDLE.
REQ-008 ram_en  output  1  RAM port enable: 1 = write ram_wdata to ram_addr, 0 = read ram_addr.
REQ-009 ram_addr  output  ADDR_W  RAM port address.
REQ-010 ram_wdata  output  DATA_W  RAM port write data.
REQ-011 ram_rdata  input  DATA_W  RAM port read data; valid one cycle after the read is issued.
REQ-012 busy  output  1  test run in progress.
REQ-013 done  output  1  run finished; held until next accepted start or reset.
REQ-014 pass  output  1  valid while done=1: 1 = no mismatch.
REQ-015 fail_addr  output  ADDR_W  address of first mismatch; 0 if none.
REQ-016 fail_phase  output  1  phase of first mismatch (0 = true pattern, 1 = inverted).

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States: IDLE, WR0, RD0, WR1, RD1, FIN.
REQ-019 Pattern P(a) = 8'hA5 XOR a (zero-extended/truncated to DATA_W); phase 1 uses ~P(a).
REQ-020 IDLE: ram_en=0, ram_addr=0, ram_wdata=0; start=1 -> WR0, busy=1, done=0, pass=0, fail_addr=0, fail_phase=0.
REQ-021 WR0: one write per cycle, ram_en=1, addresses 0..DEPTH-1 ascending, data P(a); after DEPTH cycles -> RD0.
REQ-022 RD0: ram_en=0, read addresses 0..DEPTH-1 ascending, one per cycle, then one drain cycle (ram_en=0, address held); ram_rdata compared against delayed expected P(a) at the edge one cycle after the read is issued.
REQ-023 WR1/RD1: identical to WR0/RD0 with ~P(a); RD1 end -> FIN.
REQ-024 FIN: busy=0, done=1, pass=1 if no mismatch recorded; FIN -> IDLE next cycle with done/pass/fail_* held.
REQ-025 Fault-free latency: busy high for exactly 4*DEPTH+2 cycles (18 for DEPTH=4); done rises on the following edge.
REQ-026 Mismatch (macro absent): record fail_addr/fail_phase, abort remaining accesses, go directly to FIN with pass=0.
REQ-027 start while busy or in FIN SHALL be ignored; start in IDLE with done=1 SHALL clear done and begin a new run.
REQ-028 Address counter SHALL not wrap beyond DEPTH-1; DEPTH=1 SHALL yield 6 busy cycles.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, ram_en=0, ram_addr=0, ram_wdata=0, busy=0, done=0, pass=0, fail_addr=0, fail_phase=0 (and err_cnt=0 when compiled).
REQ-030 Reset mid-run SHALL abandon the run without a done indication; a new start is required.

Configuration
REQ-031 Macro DPRAM_BIST_ERRLOG_EN defined: extra output err_cnt (4 bits, saturating at 15) counts every mismatch; run never aborts and always completes 4*DEPTH+2 busy cycles; fail_addr/fail_phase capture the first mismatch only.
REQ-032 Macro undefined: no err_cnt port; abort-on-first-mismatch per REQ-026.

Verification
REQ-033 Fault-free RAM model, DEPTH=4, start pulse -> writes A5,A4,A7,A6 to addr 0..3, then 5A,5B,58,59; busy 18 cycles; done=1, pass=1.
REQ-034 Model forces ram_rdata bit 0 high at addr 2 -> phase 1 read mismatch (58 vs 59) -> done=1, pass=0, fail_addr=2, fail_phase=1, busy ends early.
REQ-035 rst asserted in cycle 7 of a run -> all outputs zero immediately; a later start runs full 18 cycles, pass=1.
REQ-036 start held high for 30 cycles -> exactly one run per IDLE visit; start during busy has no effect on address sequence.
REQ-037 With DPRAM_BIST_ERRLOG_EN, faults at addr 1 and 3 (phase 0) -> 18 busy cycles, err_cnt=2, fail_addr=1, fail_phase=0, pass=0.
